// File: rtl/rx_iq_packer_if.sv
// I/Q sample input and byte-stream output bundle for rx_iq_packer.
// The slave modport is the packer side, master is the receiver/packetiser side.
interface rx_iq_packer_if;
    logic        in_strobe;
    logic [23:0] in_I;
    logic [23:0] in_Q;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_first;
    logic        out_last;

    modport master (
        output in_strobe,
        output in_I,
        output in_Q,
        output out_ready,
        input  out_data,
        input  out_valid,
        input  out_first,
        input  out_last
    );

    modport slave (
        input  in_strobe,
        input  in_I,
        input  in_Q,
        input  out_ready,
        output out_data,
        output out_valid,
        output out_first,
        output out_last
    );
endinterface

// File: rtl/rx_iq_packer.sv
// Buffers strobed 24-bit I/Q pairs in a FIFO and emits each as six big-endian bytes
// (I MSB first, then Q) on a valid/ready stream; dropped pairs are flagged and counted.
module rx_iq_packer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic            clock,
    input  logic            reset,
    rx_iq_packer_if.slave   bus,
    output logic [AW:0]     level,
    output logic            overflow,
    output logic [15:0]     overflow_count,
    input  logic            clear_overflow
);

    localparam logic [0:0]  StIdle    = 1'b0;
    localparam logic [0:0]  StSend    = 1'b1;
    localparam logic [AW:0] FullLevel = (AW + 1)'(DEPTH);

    logic [47:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic [0:0]    state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [47:0]   shreg_q, shreg_d;
    logic          overflow_q;
    logic [15:0]   overflow_count_q;

    logic full;
    logic push;
    logic drop;
    logic pop;
    logic hshake;
    logic last_byte;

    always_comb begin
        full      = (level_q == FullLevel);
        push      = bus.in_strobe && !full;
        drop      = bus.in_strobe && full;
        hshake    = (state_q == StSend) && bus.out_ready;
        last_byte = (idx_q == 3'd5);
    end

    // Serialiser: the head byte always sits in shreg_q[47:40]; a handshake shifts the next one up.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    shreg_d = mem[rd_ptr_q];
                    idx_d   = 3'd0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (hshake) begin
                    if (!last_byte) begin
                        idx_d   = idx_q + 3'd1;
                        shreg_d = {shreg_q[39:0], 8'h00};
                    end else if (level_q != '0) begin
                        // Back-to-back pairs: reload without an idle bubble.
                        pop     = 1'b1;
                        shreg_d = mem[rd_ptr_q];
                        idx_d   = 3'd0;
                    end else begin
                        shreg_d = '0;
                        idx_d   = 3'd0;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = 3'd0;
                shreg_d = '0;
            end
        endcase
    end

    always_comb begin
        level_d = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    // Storage has no reset; the pointers and level define what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= {bus.in_I, bus.in_Q};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= StIdle;
            idx_q    <= 3'd0;
            shreg_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    // A drop in the same cycle as a clear wins, leaving exactly one counted drop.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q       <= 1'b0;
            overflow_count_q <= 16'h0000;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (clear_overflow) begin
                overflow_count_q <= 16'h0001;
            end else if (overflow_count_q != 16'hFFFF) begin
                overflow_count_q <= overflow_count_q + 16'h0001;
            end
        end else if (clear_overflow) begin
            overflow_q       <= 1'b0;
            overflow_count_q <= 16'h0000;
        end
    end

    always_comb begin
        bus.out_valid  = (state_q == StSend);
        bus.out_data   = shreg_q[47:40];
        bus.out_first  = (state_q == StSend) && (idx_q == 3'd0);
        bus.out_last   = (state_q == StSend) && last_byte;
        level          = level_q;
        overflow       = overflow_q;
        overflow_count = overflow_count_q;
    end

endmodule

// File: tb/tb_rx_iq_packer.sv
// Directed and randomized bench for rx_iq_packer; a byte-queue reference model is
// checked by a stream monitor, with directed checks for latency, overflow and reset.
module tb_rx_iq_packer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clear_overflow = 1'b0;
    logic [4:0]  level;
    logic        overflow;
    logic [15:0] overflow_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    rx_iq_packer_if bus ();

    rx_iq_packer #(
        .DEPTH (16),
        .AW    (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus),
        .level          (level),
        .overflow       (overflow),
        .overflow_count (overflow_count),
        .clear_overflow (clear_overflow)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $fatal(1, "FAIL global_timeout observed=running required=finished");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One-cycle strobe; a kept pair is appended to the expected byte stream.
    task automatic strobe(input logic [23:0] i_s, input logic [23:0] q_s, input bit kept);
        bus.in_strobe = 1'b1;
        bus.in_I      = i_s;
        bus.in_Q      = q_s;
        if (kept) begin
            exp_q.push_back(i_s[23:16]);
            exp_q.push_back(i_s[15:8]);
            exp_q.push_back(i_s[7:0]);
            exp_q.push_back(q_s[23:16]);
            exp_q.push_back(q_s[15:8]);
            exp_q.push_back(q_s[7:0]);
        end
        tick();
        bus.in_strobe = 1'b0;
    endtask

    task automatic drain(input string tag, input int bound);
        for (int k = 0; k < bound && exp_q.size() != 0; k++) tick();
        check(tag, exp_q.size(), 0);
    endtask

    // Stream monitor: samples on the falling edge, between input updates and the next handshake.
    int         byte_pos = 0;
    bit         prev_stall = 1'b0;
    logic [9:0] prev_out = '0;

    always @(negedge clock) begin
        if (reset) begin
            byte_pos   = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_byte", {bus.out_first, bus.out_last, bus.out_data}, prev_out);
            end
            if (bus.out_valid && bus.out_ready) begin
                check("byte_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("byte_data", bus.out_data, exp_q.pop_front());
                    check("byte_first", bus.out_first, byte_pos == 0);
                    check("byte_last", bus.out_last, byte_pos == 5);
                    byte_pos = (byte_pos + 1) % 6;
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = {bus.out_first, bus.out_last, bus.out_data};
        end
    end

    initial begin
        logic [7:0] sp [6];
        int gaps;
        sp = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
        bus.in_strobe = 1'b0;
        bus.in_I      = '0;
        bus.in_Q      = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_valid", bus.out_valid, 0);
        check("rst_first", bus.out_first, 0);
        check("rst_last", bus.out_last, 0);
        check("rst_data", bus.out_data, 8'h00);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_count", overflow_count, 0);
        reset = 1'b0;
        tick();

        // Single pair latency and byte order
        bus.out_ready = 1'b1;
        strobe(24'h123456, 24'hABCDEF, 1'b1);
        check("sp_level_t1", level, 1);
        check("sp_valid_t1", bus.out_valid, 0);
        tick();
        check("sp_level_t2", level, 0);
        for (int b = 0; b < 6; b++) begin
            if (b != 0) tick();
            check("sp_valid", bus.out_valid, 1);
            check("sp_data", bus.out_data, sp[b]);
            check("sp_first", bus.out_first, b == 0);
            check("sp_last", bus.out_last, b == 5);
        end
        tick();
        check("sp_valid_end", bus.out_valid, 0);

        // Back-pressure: ready pattern 1,0,0 repeating
        bus.out_ready = 1'b0;
        strobe(24'h123456, 24'hABCDEF, 1'b1);
        for (int c = 0; c < 40; c++) begin
            bus.out_ready = (c % 3 == 0);
            tick();
        end
        bus.out_ready = 1'b0;
        check("bp_drained", exp_q.size(), 0);
        check("bp_idle", bus.out_valid, 0);

        // Burst of 18 into a stalled output: one in serialiser, 16 stored, one dropped
        for (int k = 0; k < 18; k++) begin
            strobe(24'($urandom()), 24'($urandom()), k < 17);
            if (k == 16) check("burst_no_ovf_yet", overflow, 0);
        end
        check("burst_level", level, 16);
        check("burst_overflow", overflow, 1);
        check("burst_count", overflow_count, 1);
        check("burst_head", bus.out_data, exp_q[0]);
        bus.out_ready = 1'b1;
        gaps = 0;
        for (int k = 0; k < 102; k++) begin
            @(negedge clock);
            if (!bus.out_valid) gaps++;
        end
        tick();
        check("burst_gaps", gaps, 0);
        check("burst_drained", exp_q.size(), 0);
        check("burst_idle", bus.out_valid, 0);

        // Clear alone, then clear racing a drop
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("clr_overflow", overflow, 0);
        check("clr_count", overflow_count, 0);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 18; k++) strobe(24'($urandom()), 24'($urandom()), k < 17);
        check("race_pre_count", overflow_count, 1);
        clear_overflow = 1'b1;
        strobe(24'($urandom()), 24'($urandom()), 1'b0);
        clear_overflow = 1'b0;
        check("race_overflow", overflow, 1);
        check("race_count", overflow_count, 1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("race_clr_overflow", overflow, 0);
        check("race_clr_count", overflow_count, 0);
        bus.out_ready = 1'b1;
        drain("race_drained", 300);

        // Reset after byte 2 of a pair with 3 pairs queued
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) strobe(24'($urandom()), 24'($urandom()), 1'b1);
        check("mid_level", level, 3);
        bus.out_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        exp_q.delete();
        tick();
        check("mid_valid", bus.out_valid, 0);
        check("mid_level_rst", level, 0);
        reset = 1'b0;
        strobe(24'h000001, 24'hFFFFFF, 1'b1);
        drain("mid_new_pair", 20);
        repeat (20) tick();
        check("mid_quiet", bus.out_valid, 0);
        check("mid_overflow", overflow, 0);

        // Continuous random stream, one pair every 8 clocks
        for (int n = 0; n < 1000; n++) begin
            strobe(24'($urandom()), 24'($urandom()), 1'b1);
            check("stream_level", level <= 5'd1, 1);
            for (int c = 0; c < 7; c++) begin
                tick();
                check("stream_level", level <= 5'd1, 1);
                check("stream_overflow", overflow, 0);
            end
        end
        drain("stream_drained", 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
